// File: rtl/uart_core.sv
// uart_core: 16550-style UART engine with a register port, TX/RX FIFOs and a runtime baud divisor.
// Optional RTS/CTS flow control is built when UART_FLOW_CONTROL_EN is defined.
module uart_core #(
    parameter int unsigned FifoDepth  = 16,
    parameter int unsigned DefaultDiv = 53,
    parameter int unsigned DivWidth   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [3:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    input  logic        uart_rxd_i,
    output logic        uart_txd_o,
    input  logic        uart_cts_ni,
    output logic        uart_rts_no,
    output logic        irq_o
);
    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam int unsigned PtrW  = AddrW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    logic [7:0]          tx_mem [FifoDepth];
    logic [7:0]          rx_mem [FifoDepth];
    logic [PtrW-1:0]     tx_wr, tx_rd, rx_wr, rx_rd, tx_cnt, rx_cnt;
    logic                tx_empty, tx_full, rx_empty, rx_full;
    logic                tx_push, tx_pop, rx_push, rx_pop;
    logic                req_ready_q, rsp_valid_q, irq_q, txd_q;
    logic [31:0]         rsp_data_q, rd_data;
    logic [DivWidth-1:0] div_q, tick_cnt;
    logic [2:0]          ie_q, sticky_q, sticky_set, sticky_clr;
    logic                accept, div_wr, tick, cts_ok, tx_idle;
    logic                txovf_set, frame_set, rxovf_set;
    logic [1:0]          reg_sel;
    uart_state_e         tx_state, rx_state;
    logic [3:0]          tx_tick, rx_tick;
    logic [2:0]          tx_bit, rx_bit;
    logic [7:0]          tx_shift, rx_shift;
    logic                rxd_prev, rx_sample, rx_stop_sample;
    logic                unused_bits;

    assign tx_cnt   = tx_wr - tx_rd;
    assign rx_cnt   = rx_wr - rx_rd;
    assign tx_empty = (tx_cnt == '0);
    assign rx_empty = (rx_cnt == '0);
    assign tx_full  = (tx_cnt == PtrW'(FifoDepth));
    assign rx_full  = (rx_cnt == PtrW'(FifoDepth));
    assign tx_idle  = tx_empty && (tx_state == ST_IDLE);

    assign accept    = req_valid_i && req_ready_q;
    assign reg_sel   = req_addr_i[3:2];
    assign div_wr    = accept && req_write_i && (reg_sel == 2'd2);
    assign tx_pop    = (tx_state == ST_IDLE) && !tx_empty && cts_ok;
    // A full FIFO still takes a byte when the same cycle frees a slot
    assign tx_push   = accept && req_write_i && (reg_sel == 2'd0) && (!tx_full || tx_pop);
    assign txovf_set = accept && req_write_i && (reg_sel == 2'd0) && tx_full && !tx_pop;
    assign rx_pop    = accept && !req_write_i && (reg_sel == 2'd0) && !rx_empty;

    assign rx_sample      = tick && (rx_tick == 4'd7);
    assign rx_stop_sample = (rx_state == ST_STOP) && rx_sample;
    assign rx_push        = rx_stop_sample && uart_rxd_i && (!rx_full || rx_pop);
    assign rxovf_set      = rx_stop_sample && uart_rxd_i && rx_full && !rx_pop;
    assign frame_set      = rx_stop_sample && !uart_rxd_i;

    assign sticky_set = {txovf_set, frame_set, rxovf_set};
    assign sticky_clr = (accept && req_write_i && (reg_sel == 2'd1)) ? req_wdata_i[5:3] : 3'b000;
    assign tick       = (tick_cnt == div_q);

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            2'd0:    rd_data = rx_empty ? 32'h100 : {24'h0, rx_mem[rx_rd[AddrW-1:0]]};
            2'd1:    rd_data = 32'({sticky_q, tx_idle, tx_full, !rx_empty});
            2'd2:    rd_data = 32'(div_q);
            default: rd_data = 32'(ie_q);
        endcase
    end

    // Register port: one outstanding request, response held until consumed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            div_q       <= DivWidth'(DefaultDiv);
            ie_q        <= '0;
            sticky_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid_q <= 1'b1;
                req_ready_q <= 1'b0;
                rsp_data_q  <= req_write_i ? 32'h0 : rd_data;
                if (req_write_i && reg_sel == 2'd2) div_q <= req_wdata_i[DivWidth-1:0];
                if (req_write_i && reg_sel == 2'd3) ie_q <= req_wdata_i[2:0];
            end else if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                req_ready_q <= 1'b1;
            end
            sticky_q <= (sticky_q & ~sticky_clr) | sticky_set;
            irq_q    <= |(ie_q & {|sticky_q, tx_empty, !rx_empty});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || div_wr || tick) tick_cnt <= '0;
        else                         tick_cnt <= tick_cnt + DivWidth'(1);
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr[AddrW-1:0]] <= req_wdata_i[7:0];
        if (rx_push) rx_mem[rx_wr[AddrW-1:0]] <= rx_shift;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            tx_wr <= tx_wr + PtrW'(tx_push);
            tx_rd <= tx_rd + PtrW'(tx_pop);
            rx_wr <= rx_wr + PtrW'(rx_push);
            rx_rd <= rx_rd + PtrW'(rx_pop);
        end
    end

    // Transmitter: each state spans 16 ticks, txd is registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state <= ST_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
        end else begin
            unique case (tx_state)
                ST_IDLE: if (tx_pop) begin
                    tx_state <= ST_START;
                    tx_tick  <= '0;
                    tx_shift <= tx_mem[tx_rd[AddrW-1:0]];
                    txd_q    <= 1'b0;
                end
                ST_START: if (tick) begin
                    tx_tick <= tx_tick + 4'd1;
                    if (tx_tick == 4'd15) begin
                        tx_state <= ST_DATA;
                        tx_bit   <= '0;
                        txd_q    <= tx_shift[0];
                    end
                end
                ST_DATA: if (tick) begin
                    tx_tick <= tx_tick + 4'd1;
                    if (tx_tick == 4'd15) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            txd_q    <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            txd_q    <= tx_shift[1];
                        end
                    end
                end
                ST_STOP: if (tick) begin
                    tx_tick <= tx_tick + 4'd1;
                    if (tx_tick == 4'd15) tx_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Receiver: mid-bit sampling on the 8th tick; leaves STOP right after its sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state <= ST_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rxd_prev <= 1'b1;
        end else begin
            rxd_prev <= uart_rxd_i;
            unique case (rx_state)
                ST_IDLE: if (rxd_prev && !uart_rxd_i) begin
                    rx_state <= ST_START;
                    rx_tick  <= '0;
                end
                ST_START: if (tick) begin
                    rx_tick <= rx_tick + 4'd1;
                    if (rx_sample && uart_rxd_i) begin
                        rx_state <= ST_IDLE;
                    end else if (rx_tick == 4'd15) begin
                        rx_state <= ST_DATA;
                        rx_bit   <= '0;
                    end
                end
                ST_DATA: if (tick) begin
                    rx_tick <= rx_tick + 4'd1;
                    if (rx_sample) rx_shift <= {uart_rxd_i, rx_shift[7:1]};
                    if (rx_tick == 4'd15) begin
                        if (rx_bit == 3'd7) rx_state <= ST_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end
                end
                ST_STOP: if (tick) begin
                    rx_tick <= rx_tick + 4'd1;
                    if (rx_sample) rx_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FLOW_CONTROL_EN
    logic rts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) rts_q <= 1'b0;
        else       rts_q <= (rx_cnt >= PtrW'(FifoDepth - 2));
    end

    assign cts_ok      = !uart_cts_ni;
    assign uart_rts_no = rts_q;
    assign unused_bits = ^{req_addr_i[1:0], req_wdata_i};
`else
    assign cts_ok      = 1'b1;
    assign uart_rts_no = 1'b0;
    assign unused_bits = ^{req_addr_i[1:0], req_wdata_i, uart_cts_ni};
`endif

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign uart_txd_o  = txd_q;
    assign irq_o       = irq_q;
endmodule

// File: doc/uart_core.md
# uart_core

Native 16550-style UART serial engine for the IO subsystem, generalised from the vendor-IP UART: parametrised FIFO depth, runtime baud divisor, interrupt masking and optional RTS/CTS flow control. Runs entirely on the system clock, with no clock wizard or clock-domain converter. Sits behind the bus-to-register adapter on the peripheral interconnect and drives `irq_o` to the interrupt controller.

## Interface
Parameters:
- `FifoDepth`, 16: entries in each of the TX and RX FIFOs. Power of two, at least 4.
- `DefaultDiv`, 53: reset value of the baud divisor.
- `DivWidth`, 16: width of the divisor register.

Ports:
- `clk_i`, input, 1: system clock.
- `rst_i`, input, 1: synchronous, active-high reset.
- `req_valid_i`, input, 1: register request valid.
- `req_ready_o`, output, 1: request accepted.
- `req_write_i`, input, 1: 1 = write, 0 = read.
- `req_addr_i`, input, 4: byte address. Only bits [3:2] are decoded.
- `req_wdata_i`, input, 32: write data.
- `rsp_valid_o`, output, 1: response valid.
- `rsp_ready_i`, input, 1: response consumed.
- `rsp_data_o`, output, 32: read data. Always 0 for writes.
- `uart_rxd_i`, input, 1: serial in. Externally synchronised; idle high.
- `uart_txd_o`, output, 1: serial out.
- `uart_cts_ni`, input, 1: clear-to-send, active low.
- `uart_rts_no`, output, 1: request-to-send, active low.
- `irq_o`, output, 1: level interrupt.

## Operation
Registers (word offset):
- 0 `DATA`
  - Write pushes [7:0] into the TX FIFO. If the FIFO is full the byte is dropped and `TXOVF` is set.
  - Read pops the RX FIFO and returns {23'b0, empty, byte}. When the FIFO is empty the read returns 0x100 and does not pop.
- 1 `STATUS`, read-only bits:
  - [0] RX not empty
  - [1] TX full
  - [2] TX idle (FIFO empty and FSM in IDLE)
- 1 `STATUS`, sticky bits, write-1-to-clear:
  - [3] `RXOVF`
  - [4] `FRAME`
  - [5] `TXOVF`
- 2 `DIV`: baud divisor, [DivWidth-1:0]. Writing it restarts the tick counter.
- 3 `IE`: interrupt enables.
  - [0] RX not empty
  - [1] TX FIFO empty
  - [2] any sticky error

`irq_o` is the registered OR of (enable & condition).

Baud generation:
- A tick fires every DIV+1 clocks.
- One bit period is 16 ticks.

TX FSM: IDLE → START → DATA → STOP → IDLE.
- Leaves IDLE when the FIFO is not empty (and, in the flow-control build, CTS is asserted). The FIFO pops on leaving IDLE.
- Each state lasts 16 ticks.
- DATA sends 8 bits, LSB first.
- STOP drives 1.

RX FSM: IDLE → START → DATA → STOP → IDLE.
- IDLE: a falling edge on rxd enters START.
- START: re-samples at tick 8. If rxd is high the edge was a glitch and the FSM returns to IDLE.
- DATA: samples at tick 8 of each bit, LSB first.
- STOP: samples at tick 8.
  - Stop = 0: the byte is discarded and `FRAME` is set.
  - Stop = 1 and FIFO full: the byte is discarded and `RXOVF` is set.
  - Otherwise the byte is pushed.
- After the sample the FSM returns to IDLE (half-bit stop is accepted).

Boundary cases:
- FIFO pointers carry log2(FifoDepth)+1 bits and wrap modulo 2·FifoDepth.
- A simultaneous push and pop on a full or empty FIFO is legal; the count is unchanged.
- A simultaneous hardware set and software clear of a sticky bit leaves the bit set.

## Timing
- One outstanding request: `req_ready_o` = !`rsp_valid_o`.
- `rsp_valid_o` rises in the cycle after acceptance and holds with stable data until `rsp_ready_i`.
- A DATA write reaches the FIFO in the acceptance cycle. `uart_txd_o` falls at most 2 clocks later when the TX FSM is IDLE.
- A popped RX byte is captured in the response register in the acceptance cycle.
- `irq_o` lags its condition by 1 clock.

Reset values:
- `req_ready_o` = 1
- `rsp_valid_o` = 0
- `rsp_data_o` = 0
- `uart_txd_o` = 1
- `uart_rts_no` = 0
- `irq_o` = 0
- FIFOs empty, sticky bits 0, IE = 0, DIV = `DefaultDiv`, both FSMs IDLE

A reset mid-frame aborts immediately: txd goes high in the next cycle, and a partial RX byte is discarded.

## Configuration
`UART_FLOW_CONTROL_EN`:
- Defined:
  - The TX FSM does not leave IDLE while `uart_cts_ni` = 1. A frame already in progress always completes.
  - `uart_rts_no` is a registered 1 when RX count ≥ FifoDepth−2, else 0.
- Undefined:
  - `uart_cts_ni` is ignored.
  - `uart_rts_no` is constant 0.

## Test plan
- DIV=0, write DATA=0x55: txd low for 16 clocks, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then stop high. `STATUS[2]` returns to 1 after 160 clocks.
- DIV=3, drive an rxd frame of 0xA3 at 64 clocks/bit: `STATUS[0]`=1, DATA read returns 0x0A3, and a second read returns 0x100.
- Drive FifoDepth+1 frames without reading: the first FifoDepth bytes are intact and `RXOVF`=1. Writing 0x08 to STATUS clears the bit.
- Drive a frame with stop=0: no push and `FRAME`=1. With IE=0x4, `irq_o` rises 1 clock after the flag.
- Drive a 3-tick rxd low glitch: no byte is received and no flags are set.
- Flow-control build: hold CTS high, write 0x41: txd stays high. Release CTS: the frame starts within 2 clocks. Fill RX to FifoDepth−2: `uart_rts_no`=1.
